e2prom_port_arb: RTL
====================

E2PROM_PORT_ARB -- requirements
Module: e2prom_port_arb

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of FRAM requesters (area scanners).
REQ-002 SHALL have parameter TMO_CYCLES, default 65535, maximum grant hold time in clk cycles.
REQ-003 SHALL have port clk, in, 1, single system clock; all logic on rising edge.
REQ-004 SHALL have port rst, in, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port im_req, in, NREQ, per-requester transaction request, held for the whole transaction.
REQ-006 SHALL have port om_gnt, out, NREQ, one-hot grant, registered.
REQ-007 SHALL have ports im_rden/im_wren/im_wr_dv, in, NREQ each, per-requester FRAM strobes.
REQ-008 SHALL have ports im_addr (NREQ*17), im_wr_len (NREQ*16), im_wdata (NREQ*8), in, flattened per-requester buses; requester k occupies slice k.
REQ-009 SHALL have ports o_e2prom_rden, o_e2prom_wren, o_e2prom_wr_dv (1), om_e2prom_addr (17), om_e2prom_wr_len (16), o_e2prom_wdata (8), out, to the FRAM controller.
REQ-010 SHALL have ports i_e2prom_rdy, i_e2prom_rd_dv (1) and im_e2prom_rdata (8), in, from the FRAM controller.
REQ-011 SHALL have ports om_rd_dv, out, NREQ, read-valid routed to the owner only; om_rdata, out, 8, broadcast read data.
REQ-012 SHALL have ports o_busy (1), om_owner (2), o_tmo_err (1, single-cycle pulse), out.

Function
REQ-013 SHALL implement FSM IDLE -> GRANT -> RELEASE -> IDLE.
REQ-014 IDLE: when i_e2prom_rdy=1 and any im_req bit is set, SHALL select the first set bit at or after ptr+1 (mod NREQ), assert that om_gnt bit on the next cycle, load om_owner, enter GRANT.
REQ-015 IDLE with i_e2prom_rdy=0 SHALL issue no grant; requests wait.
REQ-016 GRANT: all FRAM outputs SHALL be a combinational mux of the owner's slice; non-owner inputs SHALL be ignored.
REQ-017 When no grant is active, all FRAM outputs SHALL be 0, so the block is compatible with wired-OR bus merging.
REQ-018 GRANT: om_rd_dv[owner] SHALL equal i_e2prom_rd_dv; other bits SHALL be 0.
REQ-019 GRANT: when im_req[owner] falls, the FSM SHALL clear om_gnt on the next cycle, set ptr to owner, and enter RELEASE.
REQ-020 RELEASE: the FSM SHALL wait for i_e2prom_rdy=1, then return to IDLE; re-arbitration therefore takes 1 cycle minimum after rdy is seen.
REQ-021 o_busy SHALL be 1 in GRANT and RELEASE, and 0 in IDLE.
REQ-022 Requests arriving during GRANT/RELEASE SHALL be held pending; no preemption.
REQ-023 A requester that drops im_req before its grant arrives SHALL not be granted.
REQ-024 With NREQ simultaneous requests, grants SHALL rotate so each requester is served once per NREQ transactions.

Reset
REQ-025 While rst=0, all outputs SHALL be 0, the FSM SHALL be IDLE, and ptr SHALL be NREQ-1 (so requester 0 wins first).
REQ-026 Reset asserted mid-grant SHALL drop the FRAM strobes immediately (asynchronous); there is no recovery handshake.

Configuration
REQ-027 With E2PROM_ARB_TMO_EN defined, a 16-bit counter SHALL run in GRANT; reaching TMO_CYCLES SHALL force RELEASE, pulse o_tmo_err for 1 cycle, and clear om_gnt.
REQ-028 Without E2PROM_ARB_TMO_EN, the counter SHALL be absent, o_tmo_err SHALL be tied to 0, and grants SHALL be held indefinitely.

Structure
REQ-029 FSM state encodings, the NREQ default and the TMO_CYCLES default SHALL live in the shared console constants package.
REQ-030 Round-robin selection SHALL be a sub-module rr_pick (req vector, ptr -> one-hot winner, valid).

Verification
REQ-031 Single request: im_req=001, rdy=1 -> om_gnt=001 one cycle later; the requester-0 addr 0x00123 appears on om_e2prom_addr.
REQ-032 Simultaneous request: im_req=111 after reset, each requester drops req 10 cycles after its grant -> grant order 001, 010, 100, 001.
REQ-033 Busy controller: im_req=010 with rdy=0 for 20 cycles -> om_gnt stays 000; gnt=010 one cycle after rdy rises.
REQ-034 Read routing: owner=2, rd_dv pulses with rdata 0xA5 -> om_rd_dv=100, om_rdata=0xA5; other requesters' strobes, held at 1, leak 0.
REQ-035 Timeout (macro on, TMO_CYCLES=100): req held -> o_tmo_err pulse at grant+100 and om_gnt cleared; macro off -> grant persists past 1000 cycles.
REQ-036 Reset mid-grant: rst=0 during write burst -> o_e2prom_wren=0 and om_gnt=000 with no clock edge required.

Source files
------------

// File: rtl/e2prom_port_arb_pkg.sv
// Shared constants and FSM state encoding for the FRAM port arbiter.
package e2prom_port_arb_pkg;

    localparam int unsigned NREQ_DEF       = 3;
    localparam int unsigned TMO_CYCLES_DEF = 65535;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/e2prom_port_arb_if.sv
// FRAM controller side of the port arbiter: strobes and buses out, ready/read data in.
interface e2prom_port_arb_if;

    logic        o_e2prom_rden;
    logic        o_e2prom_wren;
    logic        o_e2prom_wr_dv;
    logic [16:0] om_e2prom_addr;
    logic [15:0] om_e2prom_wr_len;
    logic [7:0]  o_e2prom_wdata;
    logic        i_e2prom_rdy;
    logic        i_e2prom_rd_dv;
    logic [7:0]  im_e2prom_rdata;

    modport master (
        output o_e2prom_rden, o_e2prom_wren, o_e2prom_wr_dv,
        output om_e2prom_addr, om_e2prom_wr_len, o_e2prom_wdata,
        input  i_e2prom_rdy, i_e2prom_rd_dv, im_e2prom_rdata
    );

    modport slave (
        input  o_e2prom_rden, o_e2prom_wren, o_e2prom_wr_dv,
        input  om_e2prom_addr, om_e2prom_wr_len, o_e2prom_wdata,
        output i_e2prom_rdy, i_e2prom_rd_dv, im_e2prom_rdata
    );

endinterface

// File: rtl/e2prom_port_arb_rr_pick.sv
// Round-robin picker: first set request bit at or after ptr+1 (mod NREQ), one-hot.
module rr_pick
    import e2prom_port_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [1:0]      i_ptr,
    output logic [NREQ-1:0] o_win,
    output logic            o_vld
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0] w_idx;

    always_comb begin
        o_win = '0;
        o_vld = 1'b0;
        w_idx = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            w_idx = IW'((32'(i_ptr) + i) % NREQ);
            if (!o_vld && i_req[w_idx]) begin
                o_win[w_idx] = 1'b1;
                o_vld        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/e2prom_port_arb.sv
// Round-robin arbiter sharing one FRAM controller between NREQ area scanners.
// Define E2PROM_ARB_TMO_EN to enable the grant-hold timeout.
module e2prom_port_arb
    import e2prom_port_arb_pkg::*;
#(
    parameter int unsigned NREQ       = NREQ_DEF,
    parameter int unsigned TMO_CYCLES = TMO_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    im_req,
    output logic [NREQ-1:0]    om_gnt,
    input  logic [NREQ-1:0]    im_rden,
    input  logic [NREQ-1:0]    im_wren,
    input  logic [NREQ-1:0]    im_wr_dv,
    input  logic [NREQ*17-1:0] im_addr,
    input  logic [NREQ*16-1:0] im_wr_len,
    input  logic [NREQ*8-1:0]  im_wdata,
    output logic [NREQ-1:0]    om_rd_dv,
    output logic [7:0]         om_rdata,
    output logic               o_busy,
    output logic [1:0]         om_owner,
    output logic               o_tmo_err,
    e2prom_port_arb_if.master  fram
);

    arb_state_t      r_state, w_state_nx;
    logic [NREQ-1:0] r_gnt, w_gnt_nx;
    logic [1:0]      r_owner, w_owner_nx;
    logic [1:0]      r_ptr, w_ptr_nx;
    logic [NREQ-1:0] w_pick;
    logic            w_pick_vld;
    logic [1:0]      w_pick_idx;
    logic            w_tmo_hit;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .i_req (im_req),
        .i_ptr (r_ptr),
        .o_win (w_pick),
        .o_vld (w_pick_vld)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (w_pick[k]) w_pick_idx = 2'(k);
        end
    end

`ifdef E2PROM_ARB_TMO_EN
    logic [15:0] r_cnt;
    logic        r_tmo;

    assign w_tmo_hit = (r_state == ST_GRANT) && (r_cnt == 16'(TMO_CYCLES - 1));
    assign o_tmo_err = r_tmo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_tmo <= 1'b0;
        end else begin
            r_cnt <= (r_state == ST_GRANT) ? r_cnt + 16'd1 : '0;
            r_tmo <= w_tmo_hit;
        end
    end
`else
    assign w_tmo_hit = 1'b0;
    assign o_tmo_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_ptr   <= 2'(NREQ - 1);
        end else begin
            r_state <= w_state_nx;
            r_gnt   <= w_gnt_nx;
            r_owner <= w_owner_nx;
            r_ptr   <= w_ptr_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_gnt_nx   = r_gnt;
        w_owner_nx = r_owner;
        w_ptr_nx   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (fram.i_e2prom_rdy && w_pick_vld) begin
                    w_gnt_nx   = w_pick;
                    w_owner_nx = w_pick_idx;
                    w_state_nx = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!im_req[r_owner] || w_tmo_hit) begin
                    w_gnt_nx   = '0;
                    w_ptr_nx   = r_owner;
                    w_state_nx = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (fram.i_e2prom_rdy) w_state_nx = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // One-hot AND-OR mux: an empty grant yields all-zero outputs for wired-OR merging.
    always_comb begin
        fram.o_e2prom_rden    = 1'b0;
        fram.o_e2prom_wren    = 1'b0;
        fram.o_e2prom_wr_dv   = 1'b0;
        fram.om_e2prom_addr   = '0;
        fram.om_e2prom_wr_len = '0;
        fram.o_e2prom_wdata   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (r_gnt[k]) begin
                fram.o_e2prom_rden    = fram.o_e2prom_rden | im_rden[k];
                fram.o_e2prom_wren    = fram.o_e2prom_wren | im_wren[k];
                fram.o_e2prom_wr_dv   = fram.o_e2prom_wr_dv | im_wr_dv[k];
                fram.om_e2prom_addr   = fram.om_e2prom_addr | im_addr[k*17 +: 17];
                fram.om_e2prom_wr_len = fram.om_e2prom_wr_len | im_wr_len[k*16 +: 16];
                fram.o_e2prom_wdata   = fram.o_e2prom_wdata | im_wdata[k*8 +: 8];
            end
        end
    end

    assign om_gnt   = r_gnt;
    assign om_owner = r_owner;
    assign o_busy   = (r_state != ST_IDLE);
    assign om_rd_dv = r_gnt & {NREQ{fram.i_e2prom_rd_dv}};
    assign om_rdata = (|r_gnt) ? fram.im_e2prom_rdata : '0;

endmodule
